uart_rx_fsm: RTL
================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame; only 8 is supported.
REQ-002 Port: clk  input  1  single clock for all logic.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: RX_IN  input  1  serial line; idles high; already synchronized to clk.
REQ-005 Port: Prescale  input  6  clk cycles per bit; legal values are 8, 16 and 32.
REQ-006 Port: PAR_EN  input  1  1 = the frame carries a parity bit.
REQ-007 Port: PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-008 Port: P_DATA  output  8  last correctly received word, LSB received first.
REQ-009 Port: data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 Port: par_err  output  1  one-cycle pulse at frame end on a parity mismatch.
REQ-011 Port: stp_err  output  1  one-cycle pulse at frame end when the stop bit is sampled 0.

Function
REQ-012 Frame format: 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1).
REQ-013 States SHALL be IDLE, START, DATA, PARITY and STOP, with a 6-bit edge_cnt and a 3-bit bit_cnt.
REQ-014 IDLE: the first cycle with RX_IN==0 counts as edge 0 of the start bit, and the FSM moves to START with edge_cnt=1.
REQ-015 Prescale, PAR_EN and PAR_TYP SHALL be latched in the cycle the frame starts and held constant until the frame ends.
REQ-016 edge_cnt SHALL increment every cycle outside IDLE and wrap from Prescale-1 to 0; every bit boundary (state or bit_cnt advance) occurs at edge_cnt==Prescale-1.
REQ-017 Each bit value SHALL be the 2-of-3 majority of RX_IN sampled at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-018 START: at the boundary, a sampled 0 moves the FSM to DATA; a sampled 1 is a glitch, so the FSM returns to IDLE with no flags.
REQ-019 DATA: each sampled bit SHALL shift into an internal shift register at the boundary. After bit_cnt==7, the FSM moves to PARITY if PAR_EN is set, otherwise to STOP.
REQ-020 PARITY: the FSM compares the sampled bit with XOR(data) for even parity or ~XOR(data) for odd parity, records the mismatch internally, and moves to STOP.
REQ-021 STOP: at the boundary the FSM returns to IDLE. In the following cycle, exactly one outcome is registered:
- stop bit 0 -> stp_err pulses;
- stop bit 1 with a parity mismatch -> par_err pulses;
- otherwise -> P_DATA takes the shift register and data_valid pulses.
- Only one of data_valid, par_err and stp_err may be high in any cycle.
REQ-022 Latency: data_valid, par_err and stp_err pulse exactly N*Prescale cycles after edge 0, where N=10 without parity and N=11 with parity.
REQ-023 Back-to-back frames: a start edge in the first IDLE cycle after STOP SHALL be accepted with no lost cycles.
REQ-024 On par_err or stp_err, P_DATA SHALL keep its previous value.
REQ-025 RX_IN held low in IDLE after an error frame SHALL be treated as a new start bit (standard break behaviour).

Reset
REQ-026 With rst high at a clk edge:
- state=IDLE;
- edge_cnt=0 and bit_cnt=0;
- shift register=0 and P_DATA=8'h00;
- data_valid, par_err and stp_err = 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no flag pulse; reception restarts on the next low RX_IN after rst is released.

Verification
REQ-028 Prescale=8, PAR_EN=0, byte 8'hA5 -> data_valid high for one cycle 80 clks after edge 0, P_DATA=8'hA5, no errors.
REQ-029 Prescale=16, PAR_EN=1, PAR_TYP=0, byte 8'h03 with parity bit 0 -> data_valid at 176 clks, P_DATA=8'h03. The same frame with parity bit 1 -> par_err pulses and P_DATA is unchanged.
REQ-030 Prescale=32, byte 8'h5A with stop bit 0 -> stp_err pulses once at 320 clks, data_valid stays 0, P_DATA is unchanged.
REQ-031 A 3-cycle low glitch on RX_IN at Prescale=8 -> the FSM returns to IDLE after 8 clks with no outputs. A single-cycle inverted sample at mid-bit inside a data bit -> the byte is still received correctly (majority vote).
REQ-032 Two frames back-to-back (8'h11 then 8'hEE, Prescale=8, no parity) -> two data_valid pulses exactly 80 clks apart with the correct P_DATA each time.
REQ-033 rst asserted during DATA of a frame -> no flag pulses, all outputs are 0. The next full frame 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Receiver-side bundle: serial line, frame configuration and received word with status pulses.
interface uart_rx_fsm_if;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start/data/parity/stop framing with 2-of-3 mid-bit majority vote.
//   state  | meaning
//   IDLE   | line idle, waiting for a low sample (edge 0 of start bit)
//   START  | confirming the start bit; a high majority means glitch
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | checking the optional parity bit
//   STOP   | sampling the stop bit; outcome pulses on the cycle after
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fsm_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [2:0]            samp_q, samp_d;
  logic [5:0]            pre_q, pre_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_mis_q, par_mis_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic [5:0] half;
  logic       at_bnd;
  logic       maj;

  assign half   = {1'b0, pre_q[5:1]};
  assign at_bnd = (edge_cnt_q == pre_q - 6'd1);
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.RX_IN) state_d = START;
      START:   if (at_bnd) state_d = maj ? IDLE : DATA;
      DATA:    if (at_bnd && bit_cnt_q == 3'(DATA_WIDTH - 1))
                 state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (at_bnd) state_d = STOP;
      STOP:    if (at_bnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    pre_d      = pre_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_mis_d  = par_mis_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q == IDLE) begin
      edge_cnt_d = 6'd0;
      // configuration is frozen for the whole frame at edge 0
      if (!bus.RX_IN) begin
        edge_cnt_d = 6'd1;
        bit_cnt_d  = 3'd0;
        par_mis_d  = 1'b0;
        pre_d      = bus.Prescale;
        par_en_d   = bus.PAR_EN;
        par_typ_d  = bus.PAR_TYP;
      end
    end else begin
      edge_cnt_d = at_bnd ? 6'd0 : edge_cnt_q + 6'd1;
      if (edge_cnt_q == half - 6'd1) samp_d[0] = bus.RX_IN;
      if (edge_cnt_q == half)        samp_d[1] = bus.RX_IN;
      if (edge_cnt_q == half + 6'd1) samp_d[2] = bus.RX_IN;

      if (at_bnd) begin
        case (state_q)
          DATA: begin
            shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          PARITY: par_mis_d = maj ^ (^shift_q) ^ par_typ_q;
          STOP: begin
            if (!maj)          se_d = 1'b1;
            else if (par_mis_q) pe_d = 1'b1;
            else begin
              dv_d     = 1'b1;
              p_data_d = shift_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= 6'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= '0;
      p_data_q   <= '0;
      samp_q     <= 3'd0;
      pre_q      <= 6'd0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_mis_q  <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      samp_q     <= samp_d;
      pre_q      <= pre_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_mis_q  <= par_mis_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;

endmodule
